// File: rtl/aes_sha_sequencer.sv
// aes_sha_sequencer
// Runs one AES encryption followed by one SHA-1 hash of the AES output.
// Handshakes with the two cores through ready/valid levels and one-cycle
// start pulses. Every wait state is bounded by TIMEOUT cycles. If a wait
// runs out, the job ends with error=1.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   start              : job request, only honoured in IDLE
//   busy/done/error    : status (done is a 1-cycle pulse, error is valid with done)
//   digest             : last SHA-1 digest (zero after an abort)
//   aes_ready/aes_result/aes_result_valid/aes_next : AES core handshake
//   sha_ready/sha_digest/sha_digest_valid/sha_init : SHA-1 core handshake
//   sha_block          : padded 512-bit block presented to the SHA-1 core
module aes_sha_sequencer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [159:0] digest,
  input  logic         aes_ready,
  input  logic [127:0] aes_result,
  input  logic         aes_result_valid,
  output logic         aes_next,
  input  logic         sha_ready,
  input  logic [159:0] sha_digest,
  input  logic         sha_digest_valid,
  output logic         sha_init,
  output logic [511:0] sha_block
);

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_AES_RDY, AES_START, AES_ACK, AES_RUN,
    WAIT_SHA_RDY, SHA_START, SHA_ACK, SHA_RUN, DONE
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  state_t         exit_state;
  logic [15:0]    wait_cnt_reg;
  logic           in_wait;
  logic           exit_cond;
  logic           timeout;

  logic           busy_reg;
  logic           done_reg;
  logic           error_reg;
  logic           aes_next_reg;
  logic           sha_init_reg;
  logic [159:0]   digest_reg;
  logic [511:0]   sha_block_reg;

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign aes_next  = aes_next_reg;
  assign sha_init  = sha_init_reg;
  assign digest    = digest_reg;
  assign sha_block = sha_block_reg;

  // Each wait state names its exit condition and successor. The generic
  // logic below then chooses between exit, timeout and staying put.
  always_comb begin
    state_next = state_reg;
    exit_state = state_reg;
    in_wait    = 1'b0;
    exit_cond  = 1'b0;
    case (state_reg)
      IDLE:         if (start) state_next = WAIT_AES_RDY;
      WAIT_AES_RDY: begin in_wait = 1'b1; exit_cond = aes_ready;  exit_state = AES_START; end
      AES_START:    state_next = AES_ACK;
      AES_ACK:      begin in_wait = 1'b1; exit_cond = !aes_ready; exit_state = AES_RUN; end
      AES_RUN:      begin in_wait = 1'b1; exit_cond = aes_ready && aes_result_valid; exit_state = WAIT_SHA_RDY; end
      WAIT_SHA_RDY: begin in_wait = 1'b1; exit_cond = sha_ready;  exit_state = SHA_START; end
      SHA_START:    state_next = SHA_ACK;
      SHA_ACK:      begin in_wait = 1'b1; exit_cond = !sha_ready; exit_state = SHA_RUN; end
      SHA_RUN:      begin in_wait = 1'b1; exit_cond = sha_ready && sha_digest_valid; exit_state = DONE; end
      DONE:         state_next = IDLE;
      default:      state_next = IDLE;
    endcase
    // A core answering in the very cycle the limit is hit still counts as success.
    timeout = in_wait && !exit_cond && (wait_cnt_reg == WAIT_LIMIT);
    if (in_wait) begin
      if (exit_cond)    state_next = exit_state;
      else if (timeout) state_next = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      aes_next_reg  <= 1'b0;
      sha_init_reg  <= 1'b0;
      digest_reg    <= '0;
      sha_block_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (in_wait && wait_cnt_reg != 16'hFFFF)
        wait_cnt_reg <= wait_cnt_reg + 16'd1;

      // Outputs are decoded from the next state so that they line up with the state register.
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_next == DONE);
      aes_next_reg <= (state_next == AES_START);
      sha_init_reg <= (state_next == SHA_START);

      if (state_reg == IDLE && state_next != IDLE)
        error_reg <= 1'b0;
      else if (timeout)
        error_reg <= 1'b1;

      // SHA-1 padding of a single 128-bit message: 1 bit, zeros, 64-bit length (128).
      if (state_reg == AES_RUN && exit_cond)
        sha_block_reg <= {aes_result, 8'h80, 312'd0, 64'h80};

      if (state_reg == SHA_RUN && exit_cond)
        digest_reg <= sha_digest;
      else if (timeout)
        digest_reg <= '0;
    end
  end

endmodule

// File: tb/tb_aes_sha_sequencer.sv
// Testbench for aes_sha_sequencer.
// Each job is described by six wait-phase lengths, measured in cycles spent in
// WAIT_AES_RDY, AES_ACK, AES_RUN, WAIT_SHA_RDY, SHA_ACK and SHA_RUN.
// The driver plays both cores so that each phase lasts exactly that long.
// At job start, the reference outcome is queued. A job aborts at the first
// phase longer than TO. The queued outcome holds the done cycle, the pulse
// cycles and counts, the error flag, the digest and the padded block.
// The monitor compares that outcome whenever done pulses.
module tb_aes_sha_sequencer;
  localparam int TO = 24;

  logic         clk = 1'b0;
  logic         reset, start;
  logic         busy, done, error, aes_next, sha_init;
  logic [159:0] digest;
  logic [511:0] sha_block;
  logic         aes_ready, aes_result_valid, sha_ready, sha_digest_valid;
  logic [127:0] aes_result;
  logic [159:0] sha_digest;

  aes_sha_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .digest(digest), .aes_ready(aes_ready),
    .aes_result(aes_result), .aes_result_valid(aes_result_valid),
    .aes_next(aes_next), .sha_ready(sha_ready), .sha_digest(sha_digest),
    .sha_digest_valid(sha_digest_valid), .sha_init(sha_init),
    .sha_block(sha_block)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         err;
    logic [159:0] dig;
    logic [511:0] blk;
    int           done_cyc;
    int           n_aes;
    int           n_sha;
    int           aes_cyc;
    int           sha_cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           w[6];
  logic [511:0] prev_blk = '0;
  logic         hold_err = 1'b0;
  logic [159:0] hold_dig = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [159:0] rand160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    aes_ready = 1'b1; aes_result_valid = 1'b0;
    sha_ready = 1'b1; sha_digest_valid = 1'b0;
  endtask

  // Drive the core inputs so that phase p's exit condition is c.
  task automatic set_cond(input int p, input bit c, input logic [127:0] res, input logic [159:0] dig);
    int r;
    r = int'($urandom_range(0, 2));
    case (p)
      0: aes_ready = c;
      1: aes_ready = !c;
      2: if (c) begin
           aes_ready = 1'b1; aes_result_valid = 1'b1; aes_result = res;
         end else begin
           aes_ready = (r == 1); aes_result_valid = (r == 2); aes_result = rand128();
         end
      3: begin aes_ready = 1'b1; aes_result_valid = 1'b0; sha_ready = c; end
      4: sha_ready = !c;
      default: if (c) begin
           sha_ready = 1'b1; sha_digest_valid = 1'b1; sha_digest = dig;
         end else begin
           sha_ready = (r == 1); sha_digest_valid = (r == 2); sha_digest = rand160();
         end
    endcase
  endtask

  // This task is called at the negedge before the edge that samples start.
  // It returns at a negedge with the DUT back in IDLE.
  // If rst_k is nonzero, reset is asserted on cycle rst_k of SHA_RUN.
  task automatic do_job(input logic [127:0] res, input logic [159:0] dig,
                        input bit hold_next, input int rst_k);
    exp_t e;
    int   abort_p, tsum, s, lim;
    bit   stop;
    abort_p = 0;
    for (int i = 0; i < 6; i++)
      if (abort_p == 0 && w[i] > TO) abort_p = i + 1;
    s    = cyc + 1;
    tsum = 0;
    for (int i = 0; i < 6; i++)
      if (abort_p == 0 || i < abort_p - 1) tsum += w[i];
    // The start states are single cycles. An abort costs exactly TO cycles in the stuck phase.
    if (abort_p == 0) tsum += 2;
    else tsum += TO + ((abort_p >= 2) ? 1 : 0) + ((abort_p >= 5) ? 1 : 0);
    e.err      = (abort_p != 0);
    e.dig      = e.err ? 160'd0 : dig;
    e.blk      = (abort_p == 0 || abort_p >= 4) ? {res, 8'h80, 312'd0, 64'h80} : prev_blk;
    e.n_aes    = (abort_p == 0 || abort_p >= 2) ? 1 : 0;
    e.n_sha    = (abort_p == 0 || abort_p >= 5) ? 1 : 0;
    e.aes_cyc  = s + w[0];
    e.sha_cyc  = s + w[0] + 1 + w[1] + w[2] + w[3];
    e.done_cyc = s + tsum;
    if (rst_k == 0) begin
      exp_q.push_back(e);
      prev_blk = e.blk; hold_err = e.err; hold_dig = e.dig;
    end
    start = 1'b1;
    stop  = 1'b0;
    for (int p = 0; p < 6 && !stop; p++) begin
      if (p == 1 || p == 4) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
      end
      lim = (w[p] > TO) ? TO : w[p];
      for (int k = 1; k <= lim; k++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        if (rst_k != 0 && p == 5 && k == rst_k) begin
          reset = 1'b1; start = 1'b0;
          @(negedge clk);
          chk("rst_mid_busy", 512'(busy), 512'(0));
          chk("rst_mid_done", 512'(done), 512'(0));
          chk("rst_mid_error", 512'(error), 512'(0));
          chk("rst_mid_digest", 512'(digest), 512'(0));
          chk("rst_mid_block", sha_block, 512'(0));
          chk("rst_mid_pulses", 512'({aes_next, sha_init}), 512'(0));
          @(negedge clk);
          reset = 1'b0;
          idle_inputs();
          prev_blk = '0; hold_err = 1'b0; hold_dig = '0;
          return;
        end
        set_cond(p, k == w[p], res, dig);
      end
      if (w[p] > TO) stop = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);              // DUT in DONE
    idle_inputs();
    start = hold_next;           // start seen in DONE must be ignored
    @(negedge clk);              // DUT in IDLE
    chk("idle_busy", 512'(busy), 512'(0));
    chk("idle_done", 512'(done), 512'(0));
    chk("idle_error_hold", 512'(error), 512'(hold_err));
    chk("idle_digest_hold", 512'(digest), 512'(hold_dig));
  endtask

  // Monitor and scoreboard
  initial begin : monitor
    exp_t e;
    int   n_aes = 0, n_sha = 0, aes_at = 0, sha_at = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_aes = 0; n_sha = 0;
      end else begin
        if (aes_next) begin
          n_aes++; aes_at = cyc;
          chk("error_cleared_on_start", 512'(error), 512'(0));
        end
        if (sha_init) begin n_sha++; sha_at = cyc; end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
          end else begin
            e = exp_q.pop_front();
            $display("job done at cycle %0d error=%0d digest=%0h", cyc, error, digest);
            chk("done_cycle", 512'(cyc), 512'(e.done_cyc));
            chk("done_error", 512'(error), 512'(e.err));
            chk("done_digest", 512'(digest), 512'(e.dig));
            chk("done_block", sha_block, e.blk);
            chk("done_busy", 512'(busy), 512'(1));
            chk("aes_next_count", 512'(n_aes), 512'(e.n_aes));
            chk("sha_init_count", 512'(n_sha), 512'(e.n_sha));
            if (e.n_aes == 1) chk("aes_next_cycle", 512'(aes_at), 512'(e.aes_cyc));
            if (e.n_sha == 1) chk("sha_init_cycle", 512'(sha_at), 512'(e.sha_cyc));
          end
          n_aes = 0; n_sha = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit nh;
    reset = 1'b1; start = 1'b0;
    aes_result = '0; sha_digest = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_error", 512'(error), 512'(0));
    chk("rst_aes_next", 512'(aes_next), 512'(0));
    chk("rst_sha_init", 512'(sha_init), 512'(0));
    chk("rst_digest", 512'(digest), 512'(0));
    chk("rst_block", sha_block, 512'(0));
    reset = 1'b0;
    @(negedge clk);

    // Nominal job: the minimum-latency path with a known AES block.
    w = '{1, 1, 1, 1, 1, 1};
    do_job(128'h00112233445566778899aabbccddeeff, rand160(), 1'b0, 0);
    // Both cores busy for 20 cycles before they accept work.
    w = '{20, 2, 3, 20, 2, 3};
    do_job(rand128(), rand160(), 1'b0, 0);
    // AES never drops ready after aes_next, so the job times out in AES_ACK.
    w = '{1, TO + 1, 1, 1, 1, 1};
    do_job(rand128(), rand160(), 1'b0, 0);
    // Each core answers exactly on the last allowed cycle, so exit beats timeout.
    w = '{TO, 1, TO, 1, 1, TO};
    do_job(rand128(), rand160(), 1'b0, 0);
    // Timeouts in the remaining kinds of wait state.
    w = '{TO + 1, 1, 1, 1, 1, 1};
    do_job(rand128(), rand160(), 1'b0, 0);
    w = '{2, 1, 2, TO + 1, 1, 1};
    do_job(rand128(), rand160(), 1'b0, 0);
    w = '{2, 1, 2, 1, 1, TO + 1};
    do_job(rand128(), rand160(), 1'b0, 0);
    // Reset while in SHA_RUN, then a fresh job completes normally.
    w = '{2, 2, 2, 2, 2, 10};
    do_job(rand128(), rand160(), 1'b0, 4);
    w = '{1, 1, 1, 1, 1, 1};
    do_job(rand128(), rand160(), 1'b0, 0);
    // Start held high through DONE begins exactly one new job.
    w = '{3, 1, 2, 1, 1, 2};
    do_job(rand128(), rand160(), 1'b1, 0);
    do_job(rand128(), rand160(), 1'b0, 0);

    // Random jobs, some back-to-back with start held through DONE.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 6; i++)
        w[i] = ($urandom_range(0, 19) == 0) ? TO + 1 : int'($urandom_range(1, TO));
      nh = (j < 39) && ($urandom_range(0, 3) == 0);
      do_job(rand128(), rand160(), nh, 0);
      if (!nh) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("all_jobs_completed", 512'(exp_q.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sha_sequencer.md
AES_SHA_SEQUENCER -- requirements
Module: aes_sha_sequencer

Parameters
REQ-001 SHALL provide TIMEOUT, default 1000, meaning the maximum cycles spent in any single wait state before abort; legal range 1..65535.

Interface
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  job request from host, sampled only in IDLE.
REQ-005 SHALL have port busy  output  1  high in every state except IDLE.
REQ-006 SHALL have port done  output  1  one-cycle completion pulse, on success or abort.
REQ-007 SHALL have port error  output  1  valid with done; 1 = timeout abort.
REQ-008 SHALL have port digest  output  160  last SHA-1 digest, held until the next done.
REQ-009 SHALL have port aes_ready  input  1  AES core idle.
REQ-010 SHALL have port aes_result  input  128  AES core output block.
REQ-011 SHALL have port aes_result_valid  input  1  aes_result valid.
REQ-012 SHALL have port aes_next  output  1  one-cycle AES start pulse.
REQ-013 SHALL have port sha_ready  input  1  SHA-1 core idle.
REQ-014 SHALL have port sha_digest  input  160  SHA-1 core digest.
REQ-015 SHALL have port sha_digest_valid  input  1  sha_digest valid.
REQ-016 SHALL have port sha_init  output  1  one-cycle SHA-1 init pulse.
REQ-017 SHALL have port sha_block  output  512  padded message block to SHA-1 core, registered.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_AES_RDY, AES_START, AES_ACK, AES_RUN, WAIT_SHA_RDY, SHA_START, SHA_ACK, SHA_RUN, DONE.
REQ-019 SHALL transition IDLE->WAIT_AES_RDY when start=1; start in any other state is ignored and not queued.
REQ-020 SHALL transition WAIT_AES_RDY->AES_START when aes_ready=1, AES_START->AES_ACK unconditionally, AES_ACK->AES_RUN when aes_ready=0, and AES_RUN->WAIT_SHA_RDY when aes_ready=1 and aes_result_valid=1.
REQ-021 SHALL, on leaving AES_RUN, load sha_block[511:384]=aes_result, sha_block[383:376]=8'h80, sha_block[375:64]=0, and sha_block[63:0]=64'h80 (SHA-1 padding for a 128-bit message).
REQ-022 SHALL transition WAIT_SHA_RDY->SHA_START when sha_ready=1, SHA_START->SHA_ACK unconditionally, SHA_ACK->SHA_RUN when sha_ready=0, and SHA_RUN->DONE when sha_ready=1 and sha_digest_valid=1, capturing sha_digest into digest.
REQ-023 SHALL drive aes_next=1 only in AES_START and sha_init=1 only in SHA_START, each exactly one cycle per job.
REQ-024 SHALL hold sha_block stable from its load until the next job's AES_RUN exit.
REQ-025 SHALL drive done=1 for exactly the one cycle in DONE, then return to IDLE; a start in DONE is ignored.
REQ-026 SHALL keep a 16-bit wait counter cleared on every state entry, incremented each cycle in the six wait states (WAIT_AES_RDY, AES_ACK, AES_RUN, WAIT_SHA_RDY, SHA_ACK, SHA_RUN), and saturating.
REQ-027 SHALL, when the counter reaches TIMEOUT-1 with the exit condition false, go to DONE with error=1, digest=0, and no further core pulses.
REQ-028 SHALL give the exit condition priority over timeout when both occur in the same cycle.
REQ-029 SHALL hold error from DONE until the next transition out of IDLE, which clears it.
REQ-030 SHALL, with aes_ready=1 at start, assert aes_next in the second cycle after start is sampled, giving a minimum start-to-aes_next latency of 2 cycles.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, enter IDLE and set busy=0, done=0, error=0, aes_next=0, sha_init=0, digest=0, sha_block=0, counter=0.
REQ-032 SHALL give reset priority over all transitions; reset mid-job abandons the job with no done pulse and no further core pulses.

Verification
REQ-033 Nominal: start; AES returns 128'h00112233445566778899aabbccddeeff -> sha_block = that value, then 8'h80, zeros, and 64'h80; one sha_init; digest = core digest; done=1 and error=0 for one cycle.
REQ-034 Busy cores: aes_ready=0 for 20 cycles after start -> aes_next is delayed until aes_ready=1; sha_ready=0 holds sha_init likewise; each pulse is still exactly one cycle.
REQ-035 Timeout: TIMEOUT=8, AES never acknowledges -> done and error asserted 8 cycles after AES_ACK entry; digest=0; sha_init never asserted.
REQ-036 Reset at SHA_RUN -> next cycle busy=0, done never pulses; a fresh start completes normally.
REQ-037 Start while busy, and start held high through DONE -> exactly one job per IDLE sample; pulse counts of aes_next and sha_init equal the number of accepted jobs.
